wallace_mult_pipe: RTL and testbench

WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

---
 rtl/wallace_mult_pipe.sv | 164 ++++++++++++++++
 tb/tb_wallace_mult_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined Wallace-tree multiplier (unsigned or Baugh-Wooley signed) with valid/ready flow control
//   clk, rst           : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  : operand handshake; a, b, signed_mode sampled on acceptance
//   out_valid/out_ready: result handshake; product is 2*WIDTH bits, 0 when out_valid=0
//   WIDTH              : operand width (4..32); STAGES: register stages = latency (1..4)
module wallace_mult_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);
    localparam int P  = 2 * WIDTH;
    localparam int NG = (P + 3) / 4;
    localparam logic [P-1:0] BW_K = (P'(1) << WIDTH) | (P'(1) << (P - 1));

    function automatic int rows_at(input int k);
        int n = WIDTH;
        for (int i = 0; i < k; i++) n = (n > 2) ? n - n / 3 : n;
        return n;
    endfunction

    function automatic int tree_levels();
        int n = WIDTH;
        int t = 0;
        while (n > 2) begin
            n = n - n / 3;
            t++;
        end
        return t;
    endfunction

    // T levels bring WIDTH rows to two; one more level folds in the Baugh-Wooley constant
    localparam int T = tree_levels();
    localparam int L = T + 1;

    function automatic logic is_cut(input int k);
        logic c = 1'b0;
        for (int s = 1; s < STAGES; s++) if ((s * L) / STAGES == k) c = 1'b1;
        return c;
    endfunction

    // Row i of the matrix; cross terms with exactly one MSB operand bit are inverted in signed mode
    function automatic logic [P-1:0] pp_row(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        logic [P-1:0] r;
        r = '0;
        for (int j = 0; j < WIDTH; j++)
            r[i+j] = (x[j] & y[i]) ^ (s & ((i == WIDTH - 1) != (j == WIDTH - 1)));
        return r;
    endfunction

    function automatic logic [P-1:0] csa_c(input logic [P-1:0] x, input logic [P-1:0] y, input logic [P-1:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    function automatic logic [P-1:0] cla(input logic [P-1:0] x, input logic [P-1:0] y);
        logic [4*NG-1:0] xe, ye, s;
        logic [3:0] g, p;
        logic c0, c1, c2, c3, gg, pg;
        xe = '0;
        ye = '0;
        s  = '0;
        xe[P-1:0] = x;
        ye[P-1:0] = y;
        c0 = 1'b0;
        for (int n = 0; n < NG; n++) begin
            g  = xe[4*n +: 4] & ye[4*n +: 4];
            p  = xe[4*n +: 4] ^ ye[4*n +: 4];
            c1 = g[0] | (p[0] & c0);
            c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
            c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
            gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
            pg = &p;
            s[4*n +: 4] = p ^ {c3, c2, c1, c0};
            c0 = gg | (pg & c0);
        end
        return s[P-1:0];
    endfunction

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !rst && !stall;

    // nd[k]: rows entering stage k; q[k]: same rows after the optional stage register
    logic [P-1:0] nd [T+1][WIDTH];
    logic [P-1:0] q  [T+1][WIDTH];
    logic         dv [T+2];
    logic         ds [T+2];

    assign dv[0] = in_valid;
    assign ds[0] = signed_mode;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign nd[0][i] = pp_row(i, a, b, signed_mode);
    end

    for (genvar k = 0; k <= T; k++) begin : g_stage
        if (is_cut(k)) begin : g_reg
            logic [P-1:0] r [WIDTH];
            logic         rv, rs;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < WIDTH; i++) r[i] <= '0;
                    rv <= 1'b0;
                    rs <= 1'b0;
                end else if (!stall) begin
                    for (int i = 0; i < WIDTH; i++) r[i] <= nd[k][i];
                    rv <= dv[k];
                    rs <= ds[k];
                end
            end
            for (genvar i = 0; i < WIDTH; i++) begin : g_q
                assign q[k][i] = r[i];
            end
            assign dv[k+1] = rv;
            assign ds[k+1] = rs;
        end else begin : g_wire
            for (genvar i = 0; i < WIDTH; i++) begin : g_q
                assign q[k][i] = nd[k][i];
            end
            assign dv[k+1] = dv[k];
            assign ds[k+1] = ds[k];
        end
        if (k < T) begin : g_red
            localparam int N = rows_at(k);
            localparam int G = N / 3;
            // each group of three rows becomes a sum row and a carry row; leftover rows pass through
            for (genvar j = 0; j < WIDTH; j++) begin : g_row
                if (j < 2 * G && j % 2 == 0) begin : g_s
                    assign nd[k+1][j] = q[k][3*(j/2)] ^ q[k][3*(j/2)+1] ^ q[k][3*(j/2)+2];
                end else if (j < 2 * G) begin : g_c
                    assign nd[k+1][j] = csa_c(q[k][3*(j/2)], q[k][3*(j/2)+1], q[k][3*(j/2)+2]);
                end else if (j < N - G) begin : g_p
                    assign nd[k+1][j] = q[k][j+G];
                end else begin : g_z
                    assign nd[k+1][j] = '0;
                end
            end
        end
    end

    logic [P-1:0] kr, fs, fc;
    assign kr = ds[T+1] ? BW_K : '0;
    assign fs = q[T][0] ^ q[T][1] ^ kr;
    assign fc = csa_c(q[T][0], q[T][1], kr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            product   <= '0;
        end else if (!stall) begin
            out_valid <= dv[T+1];
            product   <= dv[T+1] ? cla(fs, fc) : '0;
        end
    end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: scoreboard bench for an 8x8/3-stage and a 16x16/4-stage multiplier
module tb_wallace_mult_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv [2], ir [2], sm [2], ov [2], ory [2];
    logic [15:0] a [2], b [2];
    logic [15:0] p8;
    logic [31:0] p16;
    int          checks = 0, passes = 0, cyc = 0;
    logic [31:0] ex_p [2][64];
    int          ex_c [2][64], ex_s [2][64];
    int          wp [2], rp [2], stalls [2];
    logic        seen [2], held [2];

    logic [7:0]  da [5] = '{8'h80, 8'hFF, 8'h7F, 8'hFF, 8'hFF};
    logic [7:0]  db [5] = '{8'h80, 8'h01, 8'h81, 8'hFF, 8'hFF};
    logic        dsm [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] dp [5] = '{16'h4000, 16'hFFFF, 16'hC0FF, 16'h0001, 16'hFE01};

    always #5 clk = ~clk;

    wallace_mult_pipe #(.WIDTH(8), .STAGES(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[0][7:0]), .b(b[0][7:0]),
        .signed_mode(sm[0]), .out_valid(ov[0]), .out_ready(ory[0]), .product(p8));

    wallace_mult_pipe #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[1]), .b(b[1]),
        .signed_mode(sm[1]), .out_valid(ov[1]), .out_ready(ory[1]), .product(p16));

    function automatic logic [31:0] model(input int w, input logic [15:0] x, input logic [15:0] y, input logic s);
        longint xs, ys, m;
        xs = longint'(x) & ((longint'(1) << w) - 1);
        ys = longint'(y) & ((longint'(1) << w) - 1);
        if (s && xs >= (longint'(1) << (w - 1))) xs -= longint'(1) << w;
        if (s && ys >= (longint'(1) << (w - 1))) ys -= longint'(1) << w;
        m = xs * ys;
        return 32'(m & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    task automatic mon(input int d);
        logic [31:0] p;
        int s, f;
        p = d ? p16 : {16'h0, p8};
        s = d ? 4 : 3;
        f = rp[d] % 64;
        if (rst) begin
            chk("rst_out_valid", ov[d], 0);
            chk("rst_in_ready", ir[d], 0);
            chk("rst_product", p, 0);
            rp[d] = wp[d];
            seen[d] = 0;
            held[d] = 0;
        end else begin
            chk("in_ready", ir[d], !(ov[d] && !ory[d]));
            if (held[d]) chk("stall_hold_valid", ov[d], 1);
            if (ov[d]) begin
                if (rp[d] == wp[d]) chk("spurious_out_valid", ov[d], 0);
                else begin
                    chk(d ? "product16" : "product8", p, ex_p[d][f]);
                    if (!seen[d] && stalls[d] == ex_s[d][f]) chk("latency", cyc - ex_c[d][f], s);
                    seen[d] = 1;
                end
                held[d] = !ory[d];
                if (!ory[d]) stalls[d]++;
                else if (rp[d] != wp[d]) begin
                    rp[d]++;
                    seen[d] = 0;
                end
            end else begin
                chk("idle_product_zero", p, 0);
                held[d] = 0;
            end
            if (iv[d] && ir[d]) begin
                ex_p[d][wp[d] % 64] = model(d ? 16 : 8, a[d], b[d], sm[d]);
                ex_c[d][wp[d] % 64] = cyc;
                ex_s[d][wp[d] % 64] = stalls[d];
                wp[d]++;
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) mon(d);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put8(input logic [7:0] x, input logic [7:0] y, input logic s);
        iv[0] = 1'b1;
        a[0]  = {8'h0, x};
        b[0]  = {8'h0, y};
        sm[0] = s;
        step();
        iv[0] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1000000");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [15:0] hold;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 0; ory[d] = 1; sm[d] = 0; a[d] = '0; b[d] = '0;
            wp[d] = 0; rp[d] = 0; stalls[d] = 0; seen[d] = 0; held[d] = 0;
        end
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst8", ir[0], 1);
        chk("in_ready_after_rst16", ir[1], 1);

        put8(8'hFF, 8'hFF, 1'b0);
        chk("early_valid0", ov[0], 0);
        step();
        chk("early_valid1", ov[0], 0);
        step();
        chk("latency3_valid", ov[0], 1);
        chk("ff_x_ff_unsigned", p8, 16'hFE01);
        step();

        for (int i = 0; i < 7; i++) begin
            if (i < 5) put8(da[i], db[i], dsm[i]);
            else step();
            if (i >= 2) chk("directed_literal", p8, dp[i-2]);
        end
        repeat (2) step();

        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 10) put8(8'($urandom), 8'($urandom), 1'($urandom));
            else step();
            if (ov[0]) cnt++;
            if (i == 1) chk("burst_not_early", ov[0], 0);
        end
        chk("burst_count", cnt, 10);

        for (int i = 0; i < 4; i++) put8(8'($urandom), 8'($urandom), 1'($urandom));
        ory[0] = 1'b0;
        hold = p8;
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1;
            a[0]  = 16'($urandom);
            b[0]  = 16'($urandom);
            step();
            chk("stall_in_ready", ir[0], 0);
            chk("stall_product_hold", p8, hold);
        end
        iv[0]  = 1'b0;
        ory[0] = 1'b1;
        repeat (6) step();

        for (int i = 0; i < 3; i++) put8(8'($urandom), 8'($urandom), 1'($urandom));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", ov[0], 0);
        chk("async_rst_product", p8, 0);
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk("in_ready_after_midrst", ir[0], 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_stale_after_rst", ov[0], 0);
        end

        for (int i = 0; i < 20000; i++) begin
            iv[1]  = ($urandom % 4) != 0;
            a[1]   = ($urandom % 8 == 0) ? 16'h8000 : 16'($urandom);
            b[1]   = ($urandom % 8 == 0) ? 16'h8000 : 16'($urandom);
            sm[1]  = 1'($urandom);
            ory[1] = ($urandom % 4) != 0;
            step();
        end
        iv[1]  = 1'b0;
        ory[1] = 1'b1;
        for (int i = 0; i < 50 && (rp[0] != wp[0] || rp[1] != wp[1]); i++) step();
        chk("drain8_empty", wp[0] - rp[0], 0);
        chk("drain16_empty", wp[1] - rp[1], 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
